branch_cond_unit: RTL and testbench
===================================

Name: branch_cond_unit

Overview:
- Consumer end of the ALU flag interface: latches the zero/negative/carry/overflow flags produced by ALU and logical ops (TST, CMP, ADD, ...).
- Accepts conditional-branch requests from the control unit and evaluates a 4-bit condition code against the latched flags.
- Returns taken / not-taken and the next PC over a valid/ready handshake.
- Stalls evaluation while a flag-producing ALU operation is still in flight.

Parameters:
- ADDR_W, 16, PC width in bits.
- OFF_W, 8, branch offset width; signed two's complement.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flag_we  in  1  ALU flag outputs are valid this cycle; latch them.
- zero_in  in  1  ALU zero flag.
- negative_in  in  1  ALU negative flag.
- carry_in  in  1  ALU carry flag.
- overflow_in  in  1  ALU overflow flag.
- alu_busy  in  1  a flag-producing op has been issued and its flags are not yet written.
- req_valid  in  1  branch request valid.
- req_ready  out  1  unit can accept a request.
- req_cond  in  4  condition code.
- req_pc  in  ADDR_W  fall-through PC (address of the next sequential instruction).
- req_off  in  OFF_W  signed branch offset.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_taken  out  1  condition true.
- resp_next_pc  out  ADDR_W  next PC.
- flags_q  out  4  latched flags {N,Z,C,V}.

Behaviour:
- Reset (async, rst=1):
  - flags_q=0, resp_valid=0, resp_taken=0, resp_next_pc=0.
  - FSM goes to IDLE.
  - Any captured request is discarded.
  - req_ready is 0 while rst=1.
- Flag register: on each clk edge with flag_we=1, flags_q <= {negative_in, zero_in, carry_in, overflow_in}. Otherwise flags_q holds.
- FSM states are IDLE, WAIT, RESP.
- req_ready = (state==IDLE) || (state==RESP && resp_ready). This gives back-to-back throughput of one request per cycle when there is no hazard.
- A request is accepted when req_valid && req_ready; req_cond, req_pc and req_off are captured into holding registers.
- Hazard rule: if alu_busy=1 or flag_we=1 in the accept cycle, go to WAIT. Otherwise evaluate using the current flags_q and go to RESP.
- WAIT:
  - Stay while alu_busy || flag_we.
  - In the first cycle where both are 0, evaluate against flags_q (now updated) and go to RESP.
- Latency: without a hazard, resp_valid rises the cycle after acceptance. With a hazard, resp_valid rises one cycle after alu_busy and flag_we both deassert.
- RESP:
  - resp_valid=1; resp_taken and resp_next_pc are registered and held stable until resp_ready=1.
  - On resp_ready with no new accept: go to IDLE and clear resp_valid.
  - On resp_ready with a simultaneous accept: apply the hazard rule to the new request.
- Flag writes that occur while in RESP do not alter an already-registered result.
- resp_next_pc = taken ? (req_pc + sign_extend(req_off)) : req_pc.
  - Sum is computed at ADDR_W bits and wraps modulo 2^ADDR_W; no overflow indication.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- req_valid while req_ready=0 is ignored. The requester must hold its request stable until it is accepted.
- If rst asserts mid-WAIT or mid-RESP, the result is lost; no response is produced for that request.

Decomposition:
- Shared package (cpu_pkg):
  - Condition code constants COND_EQ through COND_NV.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM state encoding.
- One combinational sub-module, branch_cond_eval: inputs cond[3:0] and flags[3:0], output taken. It is reused by the future predicated-execution logic.

Test Plan:
1. flag_we with Z=1 (others 0); two cycles later request cond=EQ, pc=0x0100, off=0x10 -> resp_valid 1 cycle after accept, taken=1, next_pc=0x0110.
2. Flags N=1,V=0; request cond=GE, pc=0x0200, off=0xF0 (-16) -> taken=0, next_pc=0x0200. Repeat with cond=LT -> taken=1, next_pc=0x01F0.
3. Wrap-around: flags Z=1; request cond=AL, pc=0xFFFC, off=0x08 -> next_pc=0x0004. Request cond=NV -> taken=0, next_pc=0xFFFC.
4. Hazard:
   - Setup: flags_q Z=0; alu_busy=1 for 3 cycles, then flag_we with Z=1.
   - Stimulus: request cond=EQ accepted in the first busy cycle.
   - Required: unit stays in WAIT, req_ready=0 throughout; resp_valid rises one cycle after flag_we deasserts, with taken=1.
5. Backpressure and back-to-back:
   - Hold resp_ready=0 for 4 cycles while toggling flags -> resp_taken and resp_next_pc stay stable.
   - Then assert resp_ready together with a new req_valid -> the new request is accepted in the same cycle and its result appears on the next cycle.
6. Reset mid-RESP: assert rst asynchronously between clock edges -> resp_valid=0 and flags_q=0 immediately. After rst deasserts, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions and the
// branch unit's state encoding.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } bcu_state_t;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Request/response handshake between the control unit (master) and the
// branch condition unit (slave).
interface branch_cond_unit_if #(
   parameter int ADDR_W = 16,
   parameter int OFF_W  = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cond;
   logic [ADDR_W-1:0] req_pc;
   logic [OFF_W-1:0]  req_off;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_taken;
   logic [ADDR_W-1:0] resp_next_pc;

   modport master (
      output req_valid, req_cond, req_pc, req_off, resp_ready,
      input  req_ready, resp_valid, resp_taken, resp_next_pc
   );

   modport slave (
      input  req_valid, req_cond, req_pc, req_off, resp_ready,
      output req_ready, resp_valid, resp_taken, resp_next_pc
   );
endinterface

// File: rtl/branch_cond_unit_eval.sv
// Pure combinational condition-code evaluator against {N,Z,C,V} flags.
// Shared with predicated-execution logic, so it carries no state.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);
   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = z;
         COND_NE: taken = !z;
         COND_CS: taken = c;
         COND_CC: taken = !c;
         COND_MI: taken = n;
         COND_PL: taken = !n;
         COND_VS: taken = v;
         COND_VC: taken = !v;
         COND_HI: taken = c && !z;
         COND_LS: taken = !c || z;
         COND_GE: taken = (n == v);
         COND_LT: taken = (n != v);
         COND_GT: taken = !z && (n == v);
         COND_LE: taken = z || (n != v);
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: latches ALU flags, evaluates branch requests and
// returns taken / next PC, stalling while flags are still being produced.
//
// state | meaning
// IDLE  | no request held, ready to accept
// WAIT  | request held, waiting for in-flight ALU flags to land
// RESP  | result registered and presented until consumer takes it
module branch_cond_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int OFF_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flag_we,
   input  logic       zero_in,
   input  logic       negative_in,
   input  logic       carry_in,
   input  logic       overflow_in,
   input  logic       alu_busy,
   branch_cond_unit_if.slave bus,
   output logic [3:0] flags_q
);
   bcu_state_t        state, state_nxt;
   logic              accept;
   logic              hazard;
   logic              req_ready_c;
   logic              resp_valid_c;
   logic              load_result;

   logic [3:0]        hold_cond;
   logic [ADDR_W-1:0] hold_pc;
   logic [OFF_W-1:0]  hold_off;

   logic [3:0]        ev_cond;
   logic [ADDR_W-1:0] ev_pc;
   logic [OFF_W-1:0]  ev_off;
   logic [ADDR_W-1:0] ev_target;
   logic              ev_taken;

   logic              resp_taken_q;
   logic [ADDR_W-1:0] resp_next_pc_q;

   assign accept = bus.req_valid && req_ready_c;
   assign hazard = alu_busy || flag_we;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = hazard ? ST_WAIT : ST_RESP;
         end
         ST_WAIT: begin
            if (!hazard) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               if (accept) state_nxt = hazard ? ST_WAIT : ST_RESP;
               else        state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ready is forced low during reset even though the state already reads IDLE
   always_comb begin
      req_ready_c  = 1'b0;
      resp_valid_c = 1'b0;
      case (state)
         ST_IDLE: req_ready_c  = !rst;
         ST_RESP: begin
            resp_valid_c = 1'b1;
            req_ready_c  = !rst && bus.resp_ready;
         end
         default: begin
            req_ready_c  = 1'b0;
            resp_valid_c = 1'b0;
         end
      endcase
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_valid_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          flags_q <= 4'b0000;
      else if (flag_we) flags_q <= {negative_in, zero_in, carry_in, overflow_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cond <= 4'd0;
         hold_pc   <= '0;
         hold_off  <= '0;
      end else if (accept) begin
         hold_cond <= bus.req_cond;
         hold_pc   <= bus.req_pc;
         hold_off  <= bus.req_off;
      end
   end

   // A hazard-free accept evaluates straight from the bus; WAIT uses the held copy
   assign ev_cond   = accept ? bus.req_cond : hold_cond;
   assign ev_pc     = accept ? bus.req_pc   : hold_pc;
   assign ev_off    = accept ? bus.req_off  : hold_off;
   assign ev_target = ev_pc + {{(ADDR_W-OFF_W){ev_off[OFF_W-1]}}, ev_off};

   branch_cond_eval u_eval (
      .cond  (ev_cond),
      .flags (flags_q),
      .taken (ev_taken)
   );

   assign load_result = (accept && !hazard) || (state == ST_WAIT && !hazard);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_taken_q   <= 1'b0;
         resp_next_pc_q <= '0;
      end else if (load_result) begin
         resp_taken_q   <= ev_taken;
         resp_next_pc_q <= ev_taken ? ev_target : ev_pc;
      end
   end

   assign bus.resp_taken   = resp_taken_q;
   assign bus.resp_next_pc = resp_next_pc_q;
endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: expected results are queued at
// request time and compared when the response handshake completes.
module tb_branch_cond_unit;
   localparam int ADDR_W = 16;
   localparam int OFF_W  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flag_we = 1'b0;
   logic zero_in = 1'b0, negative_in = 1'b0, carry_in = 1'b0, overflow_in = 1'b0;
   logic alu_busy = 1'b0;
   logic [3:0] flags_q;

   int checks = 0;
   int failures = 0;

   logic [3:0] mflags = 4'b0000;        // model of {N,Z,C,V}
   logic [ADDR_W:0] sb_q[$];            // {taken, next_pc}

   branch_cond_unit_if #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

   branch_cond_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flag_we     (flag_we),
      .zero_in     (zero_in),
      .negative_in (negative_in),
      .carry_in    (carry_in),
      .overflow_in (overflow_in),
      .alu_busy    (alu_busy),
      .bus         (bus.slave),
      .flags_q     (flags_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic model_taken(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy & !z;
         4'd9:  return !cy | z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z & (n == v);
         4'd13: return z | (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [ADDR_W:0] model_resp(input logic [3:0] c, input logic [ADDR_W-1:0] pc,
                                                  input logic [OFF_W-1:0] off, input logic [3:0] f);
      logic t;
      logic [ADDR_W-1:0] tgt;
      t = model_taken(c, f);
      tgt = pc + ADDR_W'($signed(off));
      return {t, t ? tgt : pc};
   endfunction

   // response monitor: pops one expectation per completed handshake
   always @(negedge clk) begin
      if (!rst && bus.resp_valid && bus.resp_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_resp", 32'(sb_q.size()), 32'd1);
         end else begin
            logic [ADDR_W:0] e;
            e = sb_q.pop_front();
            chk("sb_taken", 32'(bus.resp_taken), 32'(e[ADDR_W]));
            chk("sb_next_pc", 32'(bus.resp_next_pc), 32'(e[ADDR_W-1:0]));
         end
      end
   end

   task automatic set_flags(input logic n, input logic z, input logic c, input logic v);
      @(posedge clk); #1;
      flag_we = 1'b1; negative_in = n; zero_in = z; carry_in = c; overflow_in = v;
      @(posedge clk); #1;
      flag_we = 1'b0;
      mflags = {n, z, c, v};
      chk("flags_q", 32'(flags_q), 32'(mflags));
   endtask

   // drive a request, wait (bounded) for acceptance; caller is at posedge+1
   task automatic send_req(input logic [3:0] c, input logic [ADDR_W-1:0] pc,
                           input logic [OFF_W-1:0] off, input logic [3:0] eval_flags);
      int n;
      bus.req_valid = 1'b1; bus.req_cond = c; bus.req_pc = pc; bus.req_off = off;
      sb_q.push_back(model_resp(c, pc, off, eval_flags));
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("req_accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_cond = 4'd0; bus.req_pc = '0; bus.req_off = '0;
      bus.resp_ready = 1'b1;
      #12;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_flags", 32'(flags_q), 32'd0);
      chk("rst_taken", 32'(bus.resp_taken), 32'd0);
      chk("rst_next_pc", 32'(bus.resp_next_pc), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);

      // 1: EQ with Z set, latency of one cycle
      set_flags(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      send_req(4'd0, 16'h0100, 8'h10, mflags);
      @(negedge clk);
      chk("t1_latency", 32'(bus.resp_valid), 32'd1);
      drain();

      // 2: GE / LT with N=1, V=0, negative offset
      set_flags(1'b1, 1'b0, 1'b0, 1'b0);
      send_req(4'd10, 16'h0200, 8'hF0, mflags);
      send_req(4'd11, 16'h0200, 8'hF0, mflags);
      drain();

      // 3: wrap-around and NV
      set_flags(1'b0, 1'b1, 1'b0, 1'b0);
      send_req(4'd14, 16'hFFFC, 8'h08, mflags);
      send_req(4'd15, 16'hFFFC, 8'h08, mflags);
      drain();

      // 4: hazard; flags land after the request is accepted
      set_flags(1'b0, 1'b0, 1'b0, 1'b0);
      alu_busy = 1'b1;
      send_req(4'd0, 16'h0300, 8'h04, 4'b0100);
      @(negedge clk);
      chk("t4_ready_busy2", 32'(bus.req_ready), 32'd0);
      chk("t4_valid_busy2", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t4_ready_busy3", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      alu_busy = 1'b0; flag_we = 1'b1; zero_in = 1'b1;
      @(negedge clk);
      chk("t4_ready_we", 32'(bus.req_ready), 32'd0);
      chk("t4_valid_we", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
      flag_we = 1'b0; mflags = 4'b0100;
      @(negedge clk);
      chk("t4_ready_last", 32'(bus.req_ready), 32'd0);
      chk("t4_valid_last", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
      chk("t4_valid_rise", 32'(bus.resp_valid), 32'd1);
      drain();

      // 5: backpressure with flag churn, then back-to-back accept
      bus.resp_ready = 1'b0;
      send_req(4'd0, 16'h0400, 8'h20, mflags);
      for (int i = 0; i < 4; i++) begin
         flag_we = 1'b1;
         {negative_in, zero_in, carry_in, overflow_in} = 4'(i * 5 + 3);
         mflags = 4'(i * 5 + 3);
         @(negedge clk);
         chk("t5_hold_valid", 32'(bus.resp_valid), 32'd1);
         chk("t5_hold_taken", 32'(bus.resp_taken), 32'd1);
         chk("t5_hold_pc", 32'(bus.resp_next_pc), 32'h0420);
         chk("t5_hold_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      flag_we = 1'b0;
      bus.resp_ready = 1'b1;
      send_req(4'd2, 16'h0500, 8'h80, mflags);
      @(negedge clk);
      chk("t5_b2b_valid", 32'(bus.resp_valid), 32'd1);
      drain();

      // sweep every condition code against random flags
      for (int c = 0; c < 16; c++) begin
         logic [3:0] f;
         f = 4'($urandom_range(0, 15));
         set_flags(f[3], f[2], f[1], f[0]);
         send_req(4'(c), 16'($urandom), 8'($urandom), mflags);
      end
      drain();

      // 6: reset mid-RESP discards the result
      bus.resp_ready = 1'b0;
      set_flags(1'b1, 1'b1, 1'b1, 1'b1);
      send_req(4'd14, 16'h0600, 8'h02, mflags);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(bus.resp_valid), 32'd0);
      chk("t6_rst_flags", 32'(flags_q), 32'd0);
      chk("t6_rst_ready", 32'(bus.req_ready), 32'd0);
      sb_q.delete();
      mflags = 4'b0000;
      @(negedge clk); #1;
      rst = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      chk("t6_post_ready", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_stale", 32'(bus.resp_valid), 32'd0);
      end
      @(posedge clk); #1;
      send_req(4'd1, 16'h0700, 8'hFE, mflags);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
